// File: rtl/pp_pipeline_accel_stream_pack.sv
// Stream packer: pops cols*rows words from a show-ahead FIFO and emits AXI-Stream beats (SOF on tuser, EOL on tlast).
// Latency: one cycle from FIFO head to m_axis_tvalid; sustains one beat per cycle.
// Backpressure: single output register; the FIFO is popped only when that register is empty or is being accepted.
module pp_pipeline_accel_stream_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_done,
  input  logic [DIM_WIDTH-1:0]    cols,
  input  logic [DIM_WIDTH-1:0]    rows,
  input  logic                    if_empty_n,
  input  logic [DATA_WIDTH-1:0]   if_dout,
  output logic                    if_read,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [DIM_WIDTH-1:0]  col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0]  row_cnt_q, row_cnt_d;
  logic                  sof_q, sof_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;

  logic load_ok;
  logic pop;
  logic col_last;
  logic row_last;

  // The output register can take a new beat when it is empty or its beat leaves this cycle.
  assign load_ok  = !tvalid_q || m_axis_tready;
  assign pop      = (state_q == S_RUN) && if_empty_n && load_ok;
  assign col_last = (col_cnt_q == (cols_q - DIM_ONE));
  assign row_last = (row_cnt_q == (rows_q - DIM_ONE));

  assign if_read       = pop;
  assign ap_idle       = (state_q == S_IDLE);
  assign ap_done       = done_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tkeep  = '1;

  // Frame control: start/latch, pixel counting, end-of-frame drain and done pulse.
  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    sof_d     = sof_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          if ((cols != '0) && (rows != '0)) begin
            state_d   = S_RUN;
            cols_d    = cols;
            rows_d    = rows;
            col_cnt_d = '0;
            row_cnt_d = '0;
            sof_d     = 1'b1;
          end else begin
            // Empty frame: nothing to move, just report completion.
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (pop) begin
          sof_d = 1'b0;
          if (col_last) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + DIM_ONE;
            if (row_last) begin
              state_d = S_DRAIN;
            end
          end else begin
            col_cnt_d = col_cnt_q + DIM_ONE;
          end
        end
      end
      S_DRAIN: begin
        // The last beat is sitting in the output register; finish once it is taken.
        if (tvalid_q && m_axis_tready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load on pop, otherwise empty out when the downstream accepts.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (pop) begin
      tdata_d  = if_dout;
      tvalid_d = 1'b1;
      tlast_d  = col_last;
      tuser_d  = sof_q;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset discarding any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      sof_q     <= 1'b0;
      done_q    <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      sof_q     <= sof_d;
      done_q    <= done_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_stream_pack.sv
// Bench for the stream packer: upstream FIFO model, tready shaping, scoreboard of expected beats.
// Expected beats are derived per frame from the word list: tuser on word 0, tlast every cols-th word.
// A negedge monitor pops the scoreboard on every accepted beat and checks handshake rules.
module tb_pp_pipeline_accel_stream_pack;

  logic        clk;
  logic        reset;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [15:0] cols;
  logic [15:0] rows;
  logic        if_empty_n;
  logic [31:0] if_dout;
  logic        if_read;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [3:0]  m_axis_tkeep;

  pp_pipeline_accel_stream_pack dut (
    .clk          (clk),
    .reset        (reset),
    .ap_start     (ap_start),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .cols         (cols),
    .rows         (rows),
    .if_empty_n   (if_empty_n),
    .if_dout      (if_dout),
    .if_read      (if_read),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tkeep (m_axis_tkeep)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Upstream show-ahead FIFO model.
  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops   = 0;
  logic        hold   = 1'b0;
  logic        flush  = 1'b0;

  assign if_empty_n = (rd_ptr != wr_ptr) && !hold;
  assign if_dout    = mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (!reset && if_read) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  // Downstream ready shaping: 0 always ready, 1 toggle, 2 random with random FIFO hiccups.
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = !m_axis_tready;
      2:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b1;
    endcase
    hold = (rmode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
  end

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;
  beat_t exp_q[$];

  // Monitor / scoreboard.
  int          cyc = 0;
  int          beats = 0;
  int          dones = 0;
  int          acc_cyc = 0;
  int          first_cyc = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic        held = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] h_dat;
  logic        h_last;
  logic        h_user;
  beat_t       e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      held      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
        chk("hold_data", 64'(m_axis_tdata), 64'(h_dat));
        chk("hold_last", 64'(m_axis_tlast), 64'(h_last));
        chk("hold_user", 64'(m_axis_tuser), 64'(h_user));
      end
      if (m_axis_tvalid && !m_axis_tready) chk("read_while_stalled", 64'(if_read), 64'(0));
      if (if_read) chk("read_while_empty", 64'(if_empty_n), 64'(1));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat got=%0h want=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_axis_tdata), 64'(e.d));
          chk("beat_last", 64'(m_axis_tlast), 64'(e.l));
          chk("beat_user", 64'(m_axis_tuser), 64'(e.u));
          if (e.u) first_cyc = cyc;
        end
        beats++;
        acc_cyc = cyc;
      end
      if (ap_done) begin
        chk("done_single_cycle", 64'(prev_done), 64'(0));
        dones++;
        done_cyc = cyc;
      end
      if (ap_start && ap_idle) start_cyc = cyc;
      held      = m_axis_tvalid && !m_axis_tready;
      h_dat     = m_axis_tdata;
      h_last    = m_axis_tlast;
      h_user    = m_axis_tuser;
      prev_done = ap_done;
    end
  end

  // Stimulus helpers.
  logic [31:0] wq[$];
  int          widx = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_frame(input int c, input int r, input bit seq);
    logic [31:0] w;
    wq.delete();
    widx = 0;
    for (int i = 0; i < c * r; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      wq.push_back(w);
      exp_q.push_back('{d: w, l: ((i % c) == (c - 1)), u: (i == 0)});
    end
  endtask

  task automatic write_fifo(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[9:0]] = wq[widx];
      widx++;
      wr_ptr++;
    end
  endtask

  task automatic write_extra(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[9:0]] = 32'hEE00_0000 | 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic start(input int c, input int r);
    cols     = 16'(c);
    rows     = 16'(r);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (!ap_done && k < budget) begin
      step();
      k++;
    end
    chk(nm, 64'(ap_done), 64'(1));
  endtask

  int p0, b0, d0, k;
  int c, r, x;

  initial begin
    reset         = 1'b1;
    ap_start      = 1'b0;
    cols          = '0;
    rows          = '0;
    m_axis_tready = 1'b1;
    step();
    step();
    chk("rst_idle", 64'(ap_idle), 64'(1));
    chk("rst_done", 64'(ap_done), 64'(0));
    chk("rst_read", 64'(if_read), 64'(0));
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_tuser", 64'(m_axis_tuser), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("tkeep_ones", 64'(m_axis_tkeep), 64'(4'hF));
    reset = 1'b0;
    step();
    step();

    // 4x2 frame of 1..8 at full rate, two spare words left behind.
    rmode = 0;
    gen_frame(4, 2, 1'b1);
    write_fifo(8);
    write_extra(2);
    p0 = pops; b0 = beats; d0 = dones;
    step();
    chk("t1_idle_before", 64'(ap_idle), 64'(1));
    start(4, 2);
    chk("t1_idle_after", 64'(ap_idle), 64'(0));
    wait_done("t1_done", 60);
    step();
    chk("t1_done_width", 64'(ap_done), 64'(0));
    chk("t1_first_latency", 64'(first_cyc - start_cyc), 64'(2));
    chk("t1_back_to_back", 64'(acc_cyc - first_cyc), 64'(7));
    chk("t1_done_latency", 64'(done_cyc - acc_cyc), 64'(1));
    chk("t1_pops", 64'(pops - p0), 64'(8));
    chk("t1_beats", 64'(beats - b0), 64'(8));
    chk("t1_leftover", 64'(wr_ptr - rd_ptr), 64'(2));
    chk("t1_dones", 64'(dones - d0), 64'(1));
    flush_fifo();

    // 3x1 frame with tready toggling every cycle.
    rmode = 1;
    gen_frame(3, 1, 1'b0);
    write_fifo(3);
    p0 = pops; b0 = beats;
    start(3, 1);
    wait_done("t2_done", 60);
    step();
    chk("t2_beats", 64'(beats - b0), 64'(3));
    chk("t2_pops", 64'(pops - p0), 64'(3));
    rmode = 0;
    step();
    step();

    // 2x2 frame with the FIFO running dry mid-frame.
    gen_frame(2, 2, 1'b0);
    write_fifo(2);
    p0 = pops; b0 = beats;
    start(2, 2);
    k = 0;
    while ((pops - p0) < 2 && k < 20) begin
      step();
      k++;
    end
    chk("t3_first_pops", 64'(pops - p0), 64'(2));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_gap_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("t3_gap_read", 64'(if_read), 64'(0));
    end
    write_fifo(2);
    wait_done("t3_done", 40);
    step();
    chk("t3_beats", 64'(beats - b0), 64'(4));
    chk("t3_pops", 64'(pops - p0), 64'(4));

    // Degenerate frames: zero columns, then zero rows.
    write_extra(3);
    p0 = pops; b0 = beats; d0 = dones;
    start(0, 5);
    chk("t4_done_pulse", 64'(ap_done), 64'(1));
    chk("t4_idle", 64'(ap_idle), 64'(1));
    step();
    chk("t4_done_drop", 64'(ap_done), 64'(0));
    start(3, 0);
    chk("t4b_done_pulse", 64'(ap_done), 64'(1));
    chk("t4b_idle", 64'(ap_idle), 64'(1));
    step();
    step();
    chk("t4_pops", 64'(pops - p0), 64'(0));
    chk("t4_beats", 64'(beats - b0), 64'(0));
    chk("t4_dones", 64'(dones - d0), 64'(2));
    flush_fifo();

    // Reset in the middle of a frame, then a fresh 2x1 frame.
    gen_frame(4, 2, 1'b0);
    write_fifo(8);
    b0 = beats;
    start(4, 2);
    k = 0;
    while ((beats - b0) < 3 && k < 30) begin
      step();
      k++;
    end
    chk("t5_three_beats", 64'(beats - b0), 64'(3));
    chk("t5_tvalid_before", 64'(m_axis_tvalid), 64'(1));
    reset = 1'b1;
    #1;
    chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t5_rst_read", 64'(if_read), 64'(0));
    chk("t5_rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("t5_rst_idle", 64'(ap_idle), 64'(1));
    exp_q.delete();
    flush_fifo();
    step();
    reset = 1'b0;
    step();
    gen_frame(2, 1, 1'b0);
    write_fifo(2);
    write_extra(1);
    p0 = pops; b0 = beats;
    start(2, 1);
    wait_done("t5_done", 40);
    step();
    chk("t5_beats", 64'(beats - b0), 64'(2));
    chk("t5_pops", 64'(pops - p0), 64'(2));
    flush_fifo();

    // ap_start held through the frame while cols/rows change after the latch.
    gen_frame(3, 2, 1'b0);
    write_fifo(6);
    write_extra(6);
    p0 = pops; b0 = beats; d0 = dones;
    cols     = 16'd3;
    rows     = 16'd2;
    ap_start = 1'b1;
    step();
    chk("t6_idle_low", 64'(ap_idle), 64'(0));
    cols = 16'd1;
    rows = 16'd1;
    k = 0;
    while (!ap_done && k < 60) begin
      step();
      k++;
      if (!ap_done) chk("t6_busy", 64'(ap_idle), 64'(0));
    end
    chk("t6_done", 64'(ap_done), 64'(1));
    ap_start = 1'b0;
    step();
    step();
    chk("t6_beats", 64'(beats - b0), 64'(6));
    chk("t6_pops", 64'(pops - p0), 64'(6));
    chk("t6_dones", 64'(dones - d0), 64'(1));
    chk("t6_leftover", 64'(wr_ptr - rd_ptr), 64'(6));
    flush_fifo();

    // Random frames under random backpressure and FIFO hiccups.
    rmode = 2;
    for (int t = 0; t < 6; t++) begin
      c = $urandom_range(1, 4);
      r = $urandom_range(1, 3);
      x = $urandom_range(0, 2);
      gen_frame(c, r, 1'b0);
      write_fifo(c * r);
      write_extra(x);
      p0 = pops; b0 = beats;
      start(c, r);
      wait_done("rnd_done", 300);
      step();
      chk("rnd_beats", 64'(beats - b0), 64'(c * r));
      chk("rnd_pops", 64'(pops - p0), 64'(c * r));
      chk("rnd_leftover", 64'(wr_ptr - rd_ptr), 64'(x));
      flush_fifo();
    end
    rmode = 0;
    step();
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/pp_pipeline_accel_stream_pack.md
PP_PIPELINE_ACCEL_STREAM_PACK -- requirements
Module: pp_pipeline_accel_stream_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO words and output TDATA.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, width of frame column/row counts.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 ap_start  input  1  frame start request, sampled in IDLE only.
REQ-006 ap_idle  output  1  high while in IDLE.
REQ-007 ap_done  output  1  one-cycle pulse at frame completion.
REQ-008 cols  input  DIM_WIDTH  pixels per row, latched at accepted start.
REQ-009 rows  input  DIM_WIDTH  rows per frame, latched at accepted start.
REQ-010 if_empty_n  input  1  upstream FIFO has data; if_dout valid combinationally when high.
REQ-011 if_dout  input  DATA_WIDTH  upstream FIFO head word.
REQ-012 if_read  output  1  pops FIFO head this cycle.
REQ-013 m_axis_tdata  output  DATA_WIDTH  output pixel word.
REQ-014 m_axis_tvalid  output  1  output beat valid.
REQ-015 m_axis_tready  input  1  downstream accept.
REQ-016 m_axis_tlast  output  1  last beat of a row.
REQ-017 m_axis_tuser  output  1  first beat of a frame (SOF).
REQ-018 m_axis_tkeep  output  DATA_WIDTH/8  byte enables, constant all-ones.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN; ap_done SHALL be a registered pulse, not a state.
REQ-020 IDLE -> RUN on ap_start with cols!=0 and rows!=0: latch cols/rows, clear col_cnt/row_cnt, set sof flag.
REQ-021 IDLE with ap_start and cols==0 or rows==0: no beats, no FIFO pops, ap_done pulses next cycle, stay IDLE.
REQ-022 ap_start outside IDLE SHALL be ignored; cols/rows changes after latch SHALL have no effect.
REQ-023 Output stage SHALL be a single register; load_ok = !m_axis_tvalid | m_axis_tready.
REQ-024 if_read = (state==RUN) & if_empty_n & load_ok; never asserted in IDLE/DRAIN, never when if_empty_n low.
REQ-025 On if_read, next cycle: tdata=if_dout, tvalid=1, tlast=(col_cnt==cols-1), tuser=sof flag; sof flag then cleared.
REQ-026 Latency FIFO head to tvalid SHALL be 1 cycle; sustained throughput 1 beat/cycle while tready=1 and FIFO non-empty.
REQ-027 Held beat (tvalid & !tready) SHALL keep tdata/tlast/tuser stable; tvalid SHALL not drop until accepted.
REQ-028 Beat with tready=1 and no new pop SHALL clear tvalid; simultaneous accept and pop SHALL load new beat, tvalid stays 1.
REQ-029 col_cnt SHALL increment per pop, wrap to 0 after cols-1 and increment row_cnt; counters are DIM_WIDTH bits, no overflow since cols,rows >= 1.
REQ-030 Pop of last pixel (col_cnt==cols-1, row_cnt==rows-1) SHALL move RUN -> DRAIN.
REQ-031 DRAIN -> IDLE when the final beat is accepted; ap_done pulses the cycle after that acceptance.
REQ-032 Total pops per frame SHALL equal cols*rows exactly; extra FIFO words remain unpopped.
REQ-033 ap_idle SHALL go low the cycle after an accepted non-degenerate start.

Reset
REQ-034 Reset SHALL asynchronously force: state IDLE, ap_idle=1, ap_done=0, if_read=0, tvalid=0, tlast=0, tuser=0, tdata=0, counters 0, sof flag 0.
REQ-035 Reset mid-frame SHALL discard any held beat and partial frame; after release the block accepts a new ap_start normally.

Verification
REQ-036 cols=4, rows=2, FIFO preloaded 1..8, tready=1 -> beats 1..8 back-to-back, tuser on 1 only, tlast on 4 and 8, ap_done 1 cycle after beat 8 accepted.
REQ-037 cols=3, rows=1, tready toggling 1/0 each cycle -> 3 beats, each stable while stalled, if_read never high when tvalid & !tready.
REQ-038 cols=2, rows=2, FIFO empty for 5 cycles mid-frame -> tvalid low during gap, if_read 0, row/col count resumes correctly, 4 beats total.
REQ-039 cols=0, rows=5, ap_start -> zero pops, zero beats, ap_done pulse next cycle, ap_idle stays 1.
REQ-040 reset asserted after 3 of 8 beats with tvalid=1 -> tvalid/if_read 0 immediately; new start with cols=2, rows=1 yields 2 beats, tuser on first.
REQ-041 ap_start held high throughout frame with cols changed mid-frame -> second start ignored until IDLE, beat count matches originally latched cols*rows.
